// File: rtl/rca_pkg.sv
// Shared definitions for the multi-cycle ripple-carry adder/subtractor.
// Contents:
//   state_t   - controller states (IDLE, RUN, DONE)
//   cnt_width - width of the chunk counter: clog2(nchunk), never below 1
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int nchunk);
    if (nchunk <= 1) begin
      return 1;
    end else begin
      return $clog2(nchunk);
    end
  endfunction

endpackage

// File: rtl/rca_seq_adder_if.sv
// Operand/result handshake bundle for rca_seq_adder.
// Signals:
//   in_valid/in_ready   - operation handshake (a, b, cin, sub qualify it)
//   a, b                - WIDTH-bit operands
//   cin                 - carry-in for add, borrow-in for subtract
//   sub                 - 0 = a+b+cin, 1 = a-b-cin
//   out_valid/out_ready - result handshake (sum, cout, ovf qualify it)
//   sum, cout, ovf      - result, MSB carry-out, signed overflow
// Modports: master drives operations and consumes results; slave is the adder.
interface rca_seq_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry full-adder chain.
// Ports:
//   a, b      - CHUNK-bit addends
//   cin       - carry into bit 0
//   sum       - CHUNK-bit sum
//   cout      - carry out of the top bit
//   c_msb_in  - carry into the top bit (used for signed overflow)
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] carry_s;

  // Full-adder ripple chain, bit 0 upward.
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = carry_s[CHUNK];
  assign c_msb_in = carry_s[CHUNK-1];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder/subtractor. A WIDTH-bit operand pair is
// processed CHUNK bits per clock, LSB chunk first, through a registered carry.
// Subtraction is a + ~b + 1 (borrow-in flips the injected carry), so cout=0
// after a subtract means a borrow occurred.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (aborts any operation in flight)
//   bus   - rca_seq_adder_if.slave: operation handshake in, result handshake out
// Timing: out_valid rises NCHUNK cycles after the accepting edge; results are
// held in DONE until out_ready, giving an issue interval of NCHUNK+2 cycles.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rca_seq_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [CW-1:0]    cnt_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_cout_s;
  logic             chunk_cmsb_s;
  logic             accept_s;
  logic             last_s;

  assign accept_s = (state_r == IDLE) && bus.in_valid;
  assign last_s   = (cnt_r == CW'(NCHUNK - 1));

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand chunk select: one-hot AND-OR mux keyed by the chunk counter.
  always_comb begin
    a_chunk_s = '0;
    b_chunk_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      a_chunk_s |= a_r[i*CHUNK +: CHUNK] & {CHUNK{cnt_r == CW'(i)}};
      b_chunk_s |= b_r[i*CHUNK +: CHUNK] & {CHUNK{cnt_r == CW'(i)}};
    end
  end

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a        (a_chunk_s),
    .b        (b_chunk_s),
    .cin      (carry_r),
    .sum      (chunk_sum_s),
    .cout     (chunk_cout_s),
    .c_msb_in (chunk_cmsb_s)
  );

  // Operand capture, per-chunk accumulation and final flag latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.cin ^ bus.sub;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_r == CW'(i)) begin
              sum_r[i*CHUNK +: CHUNK] <= chunk_sum_s;
            end
          end
          carry_r <= chunk_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            cout_r <= chunk_cout_s;
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_r  <= chunk_cmsb_s ^ chunk_cout_s;
          end
        end
        DONE: begin
          // Result held stable until the consumer takes it.
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Result-valid flag, registered alongside the DONE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nx_s == DONE);
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule
